// File: rtl/mini_pkg.sv
// mini_pkg: shared MiniMicro types and constants for the fetch stage and writeback decode.
package mini_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] R15_OFFSET = 32'd8;
  localparam logic [3:0] REG_PC = 4'hF;
endpackage

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, single-outstanding instruction fetch and redirect absorption.
module fetch_pc_unit
  import mini_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        br_en,
  input  logic [31:0] br_target,
  input  logic        pc_wr_en,
  input  logic [31:0] pc_wr_data,
  output logic [31:0] r15
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d, instr_q, instr_d, r15_q, r15_d;
  logic        redir;
  logic [31:0] tgt;
  assign redir = pc_wr_en | br_en;
  // R15 writeback comes from an older instruction than the branch, so it wins
  assign tgt = (pc_wr_en ? pc_wr_data : br_target) & 32'hFFFF_FFFC;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    r15_d   = r15_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        pc_d    = redir ? tgt : pc_q;
      end
      FETCH: begin
        if (imem_ack && !redir) begin
          state_d = HOLD;
          instr_d = imem_rdata;
          r15_d   = pc_q + R15_OFFSET;
          pc_d    = pc_q + PC_STEP;
        end else if (imem_ack) begin
          pc_d = tgt;
        end else if (redir) begin
          state_d = DRAIN;
          tgt_d   = tgt;
        end
      end
      DRAIN: begin
        tgt_d = redir ? tgt : tgt_q;
        if (imem_ack) begin
          state_d = FETCH;
          pc_d    = redir ? tgt : tgt_q;
        end
      end
      HOLD: begin
        state_d = (redir || instr_ready) ? FETCH : HOLD;
        pc_d    = redir ? tgt : pc_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= RESET_VECTOR;
      instr_q <= '0;
      r15_q   <= RESET_VECTOR + R15_OFFSET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      r15_q   <= r15_d;
    end
  end
  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == HOLD);
  assign r15         = r15_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed and randomized checks of fetch_pc_unit against a transaction-level model.
module tb_fetch_pc_unit;
  localparam logic [31:0] RV = 32'h100;
  logic clk = 0, rst_n = 0, imem_ack = 0, instr_ready = 0, br_en = 0, pc_wr_en = 0;
  logic [31:0] imem_rdata = 0, br_target = 0, pc_wr_data = 0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instr, r15;
  int total = 0, bad = 0;
  // model: starting = one-cycle idle after reset; busy = request outstanding; flush = its data will be dropped
  logic m_start, m_busy, m_flush, m_valid;
  logic [31:0] m_pc, m_tgt, m_instr, m_r15;
  logic [31:0] sv_instr, sv_r15;
  fetch_pc_unit #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .br_en(br_en), .br_target(br_target),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data), .r15(r15)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic cyc(input logic rn, input logic ack, input logic [31:0] rd, input logic rdy,
                     input logic be, input logic [31:0] bt, input logic we, input logic [31:0] wd);
    logic redir;
    logic [31:0] t;
    rst_n = rn; imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
    br_en = be; br_target = bt; pc_wr_en = we; pc_wr_data = wd;
    redir = be | we;
    t = {(we ? wd[31:2] : bt[31:2]), 2'b00};
    if (!rn) begin
      m_start = 1; m_busy = 0; m_flush = 0; m_valid = 0;
      m_pc = RV; m_tgt = RV; m_instr = 0; m_r15 = RV + 8;
    end else if (m_start) begin
      m_start = 0; m_busy = 1;
      if (redir) m_pc = t;
    end else if (m_busy) begin
      if (ack && (m_flush || redir)) begin
        m_pc = redir ? t : m_tgt; m_flush = 0;
      end else if (ack) begin
        m_busy = 0; m_valid = 1; m_instr = rd; m_r15 = m_pc + 8; m_pc = m_pc + 4;
      end else if (redir) begin
        m_flush = 1; m_tgt = t;
      end
    end else if (m_valid && (redir || rdy)) begin
      m_valid = 0; m_busy = 1;
      if (redir) m_pc = t;
    end
    @(posedge clk);
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("instr", instr, m_instr);
    chk("r15", r15, m_r15);
  endtask
  task automatic idle(input logic ack, input logic rdy);
    cyc(1, ack, $urandom, rdy, 0, 0, 0, 0);
  endtask
  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hdead, 1, 0, 0, 0, 0);
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_instr", instr, 0);
    chk("rst_r15", r15, 32'h108);
    idle(0, 1);
    for (int k = 0; k < 3; k++) begin
      chk("seq_addr", imem_addr, 32'h100 + 32'(4 * k));
      idle(1, 1);
      chk("seq_r15", r15, 32'h108 + 32'(4 * k));
      chk("seq_valid", {31'b0, instr_valid}, 1);
      idle(0, 1);
    end
    idle(1, 0);
    sv_instr = instr; sv_r15 = r15;
    repeat (5) begin
      idle(0, 0);
      chk("hold_instr", instr, sv_instr);
      chk("hold_r15", r15, sv_r15);
      chk("hold_valid", {31'b0, instr_valid}, 1);
      chk("hold_req", {31'b0, imem_req}, 0);
    end
    cyc(1, 0, 0, 0, 1, 32'h200, 1, 32'h303);
    chk("both_redir", imem_addr, 32'h300);
    cyc(1, 1, 32'hbad, 1, 1, 32'h10, 0, 0);
    chk("ack_redir", imem_addr, 32'h10);
    cyc(1, 0, 0, 1, 1, 32'h400, 0, 0);
    chk("drain_addr1", imem_addr, 32'h10);
    idle(0, 1);
    chk("drain_addr2", imem_addr, 32'h10);
    idle(1, 1);
    chk("drain_next", imem_addr, 32'h400);
    chk("drain_discard", {31'b0, instr_valid}, 0);
    cyc(1, 0, 0, 1, 1, 32'h600, 0, 0);
    cyc(1, 0, 0, 1, 1, 32'h500, 0, 0);
    idle(1, 1);
    chk("drain_latest", imem_addr, 32'h500);
    cyc(1, 1, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    idle(1, 0);
    chk("wrap_r15", r15, 32'h4);
    idle(0, 1);
    chk("wrap_addr", imem_addr, 32'h0);
    cyc(0, 1, 32'h55, 1, 0, 0, 0, 0);
    chk("rst_mid_req", {31'b0, imem_req}, 0);
    chk("rst_mid_valid", {31'b0, instr_valid}, 0);
    idle(1, 1);
    chk("restart_addr", imem_addr, 32'h100);
    chk("restart_valid", {31'b0, instr_valid}, 0);
    repeat (3000) begin
      cyc(($urandom % 200) != 0, (m_busy || m_start) ? (($urandom % 3) == 0) : 1'b0,
          $urandom, $urandom % 2, ($urandom % 8) == 0, $urandom, ($urandom % 10) == 0, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
